// File: rtl/riscboy_ppu_pixel_unpack_if.sv
// Handshake bundle between the fetch FIFO, the pixel unpacker and the
// palette/blend stage. "master" is the surrounding fetch/blend logic and
// "slave" is the unpacker itself.
interface riscboy_ppu_pixel_unpack_if #(
    parameter int W_DATA    = 32,
    parameter int W_PIX_MAX = 16,
    parameter int W_CNT     = $clog2(W_DATA) + 1
);

    // Fetch side: packed words plus the per-word depth/skip controls
    logic [W_DATA-1:0]    in_data;
    logic [2:0]           in_log_bpp;
    logic [W_CNT-1:0]     in_skip;
    logic                 in_vld;
    logic                 in_rdy;

    // Blend side: one pixel per handshake, plus replay/discard controls
    logic [W_PIX_MAX-1:0] out_pix;
    logic                 out_vld;
    logic                 out_rdy;
    logic                 rewind;
    logic                 flush;

    modport master (
        output in_data, in_log_bpp, in_skip, in_vld, out_rdy, rewind, flush,
        input  in_rdy, out_pix, out_vld
    );

    modport slave (
        input  in_data, in_log_bpp, in_skip, in_vld, out_rdy, rewind, flush,
        output in_rdy, out_pix, out_vld
    );

endinterface

// File: rtl/riscboy_ppu_pixel_unpack.sv
// PPU pixel unpacker: takes packed words from the pixel fetcher and emits
// one pixel per cycle, LSB-first, at 1/2/4/8/16 bpp chosen per word. A shadow
// copy of the last loaded word (after its leading-pixel skip) lets the blender
// rewind and replay the word, e.g. when a sprite span restarts.
module riscboy_ppu_pixel_unpack #(
    parameter int W_DATA    = 32,
    parameter int W_PIX_MAX = 16,
    parameter int W_CNT     = $clog2(W_DATA) + 1
) (
    input logic                        clk,
    input logic                        rst,
    riscboy_ppu_pixel_unpack_if.slave  bus
);

    // Skip is scaled by up to 16 bits per pixel before shifting the word
    localparam int W_SHAMT = W_CNT + 4;

    // Live word
    logic [W_DATA-1:0]    pix_buf_q, pix_buf_d;
    logic [W_CNT-1:0]     cnt_q, cnt_d;
    logic [2:0]           lbpp_q, lbpp_d;

    // Shadow copy of the most recent load, post-skip
    logic [W_DATA-1:0]    sh_buf_q, sh_buf_d;
    logic [W_CNT-1:0]     sh_cnt_q, sh_cnt_d;
    logic [2:0]           sh_lbpp_q, sh_lbpp_d;
    logic                 sh_vld_q, sh_vld_d;

    // Load-side decode of the incoming word
    logic [W_CNT-1:0]     ld_ppw;
    logic [W_SHAMT-1:0]   ld_shamt;
    logic [W_DATA-1:0]    ld_buf;
    logic [W_CNT-1:0]     ld_cnt;

    // Output-side decode of the live word
    logic [4:0]           pix_bits;
    logic [W_PIX_MAX-1:0] pix_mask;

    logic                 load_fire;
    logic                 shift_fire;

    // Compute the post-skip word and pixel count for a word being loaded
    always_comb begin
        ld_ppw   = W_CNT'(W_DATA >> bus.in_log_bpp);
        ld_shamt = W_SHAMT'(bus.in_skip) << bus.in_log_bpp;
        ld_buf   = bus.in_data >> ld_shamt;
        ld_cnt   = (bus.in_skip >= ld_ppw) ? '0 : (ld_ppw - bus.in_skip);
    end

    // Present the low pixel of the live word, zero-extended above the active depth
    always_comb begin
        pix_bits = 5'd1 << lbpp_q;
        pix_mask = ~({W_PIX_MAX{1'b1}} << pix_bits);
    end

    assign bus.out_vld = (cnt_q != '0);
    assign bus.out_pix = pix_buf_q[W_PIX_MAX-1:0] & pix_mask;

    // A new word is taken when the live one is empty or is handing off its
    // last pixel this cycle; rewind/flush cycles never consume input.
    assign bus.in_rdy = !bus.flush && !bus.rewind &&
                        ((cnt_q == '0) || ((cnt_q == W_CNT'(1)) && bus.out_rdy));

    assign load_fire  = bus.in_vld && bus.in_rdy;
    assign shift_fire = bus.out_vld && bus.out_rdy;

    // Next-state selection: flush > rewind > load > shift
    always_comb begin
        // NOTE: every _d starts from its _q so no branch can infer a latch.
        pix_buf_d = pix_buf_q;
        cnt_d     = cnt_q;
        lbpp_d    = lbpp_q;
        sh_buf_d  = sh_buf_q;
        sh_cnt_d  = sh_cnt_q;
        sh_lbpp_d = sh_lbpp_q;
        sh_vld_d  = sh_vld_q;

        if (bus.flush) begin
            // Buffers are left as-is; with both counts/valids cleared they are unobservable
            cnt_d    = '0;
            sh_vld_d = 1'b0;
        end else if (bus.rewind) begin
            // A pixel handshaken this cycle still counts downstream, but the
            // live state is replaced by the shadow regardless
            if (sh_vld_q) begin
                pix_buf_d = sh_buf_q;
                cnt_d     = sh_cnt_q;
                lbpp_d    = sh_lbpp_q;
            end
        end else if (load_fire) begin
            pix_buf_d = ld_buf;
            cnt_d     = ld_cnt;
            lbpp_d    = bus.in_log_bpp;
            sh_buf_d  = ld_buf;
            sh_cnt_d  = ld_cnt;
            sh_lbpp_d = bus.in_log_bpp;
            sh_vld_d  = 1'b1;
        end else if (shift_fire) begin
            pix_buf_d = pix_buf_q >> pix_bits;
            cnt_d     = cnt_q - W_CNT'(1);
        end
    end

    // State registers, cleared asynchronously so no stale pixel survives reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_buf_q <= '0;
            cnt_q     <= '0;
            lbpp_q    <= '0;
            sh_buf_q  <= '0;
            sh_cnt_q  <= '0;
            sh_lbpp_q <= '0;
            sh_vld_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            pix_buf_q <= pix_buf_d;
            cnt_q     <= cnt_d;
            lbpp_q    <= lbpp_d;
            sh_buf_q  <= sh_buf_d;
            sh_cnt_q  <= sh_cnt_d;
            sh_lbpp_q <= sh_lbpp_d;
            sh_vld_q  <= sh_vld_d;
        end
    end

endmodule

// File: doc/riscboy_ppu_pixel_unpack.md
# riscboy_ppu_pixel_unpack

Parametrised pixel unpacker for the PPU fetch path: accepts packed words from the pixel fetcher and emits one pixel per cycle at a per-word selectable depth (1/2/4/8/16 bpp), LSB-first. It keeps a shadow copy of the most recently loaded word so the blender can rewind and replay it, for example when a sprite span restarts. It also supports a starting-pixel skip for fine horizontal scroll. It sits between the fetch FIFO and the palette/blend stage, with valid/ready handshakes on both sides.

## Interface
- W_DATA, 32: packed word width; must be a power of two, at least 16.
- W_PIX_MAX, 16: output pixel width; the largest supported bpp.
- W_CNT, $clog2(W_DATA)+1: pixel counter width (derived; do not override).
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  W_DATA  packed pixel word.
- in_log_bpp  in  3  log2(bits per pixel), 0..4; sampled with the word.
- in_skip  in  W_CNT  number of leading pixels to discard; sampled with the word.
- in_vld  in  1  input word valid.
- in_rdy  out  1  unpacker can accept a word this cycle.
- out_pix  out  W_PIX_MAX  current pixel, zero-extended above the active bpp.
- out_vld  out  1  out_pix valid.
- out_rdy  in  1  consumer takes the pixel.
- rewind  in  1  restore the shadow word to its post-skip state.
- flush  in  1  discard the live and shadow words.

## Operation
- State:
  - buf: W_DATA bits.
  - cnt: pixels remaining, W_CNT bits.
  - lbpp: latched bpp code, 3 bits.
  - Shadow set: sh_buf, sh_cnt, sh_lbpp, sh_vld.
- Derived signals:
  - out_vld = (cnt != 0).
  - out_pix = buf[(1<<lbpp)-1:0], zero-extended.
  - in_rdy = !flush && !rewind && (cnt == 0 || (cnt == 1 && out_rdy)).
- Load (in_vld && in_rdy):
  - ppw = W_DATA >> in_log_bpp.
  - buf <= in_data >> (in_skip << in_log_bpp).
  - cnt <= (in_skip >= ppw) ? 0 : ppw - in_skip.
  - lbpp <= in_log_bpp.
  - The shadow set takes the same post-skip values, and sh_vld <= 1.
- Shift (out_vld && out_rdy, and no load, rewind or flush this cycle): buf <= buf >> (1<<lbpp); cnt <= cnt - 1.
- Rewind: if sh_vld, the live set is loaded from the shadow set, whether or not the live word is exhausted. If !sh_vld, rewind is a no-op. A pixel handshaken in the same cycle is still counted as delivered downstream, but the live state comes from the shadow.
- Flush: cnt <= 0; sh_vld <= 0; buf and sh_buf are left unchanged (don't-care).
- Priority: flush > rewind > load > shift. Load and final-pixel shift in the same cycle are legal: the load wins and there is no bubble.
- Mid-word changes to in_log_bpp or in_skip have no effect; only the values sampled at load are used.
- in_log_bpp values giving (1<<in_log_bpp) > W_PIX_MAX are illegal. The bench asserts they never occur.

## Timing
- Reset values:
  - buf, sh_buf = 0.
  - cnt, sh_cnt = 0.
  - lbpp, sh_lbpp = 0.
  - sh_vld = 0.
  - Therefore out_vld = 0, out_pix = 0, in_rdy = 1 while rst is deasserted and flush and rewind are low.
- Reset asserted mid-word clears everything asynchronously; no pixel is emitted after reset deasserts until a new load.
- Load to first out_vld: 1 cycle (registered).
- Throughput: 1 pixel per cycle. Back-to-back words stream with no gap when in_vld is high on the final-pixel cycle.
- Word length in cycles is ppw - skip, with out_rdy held high.
- A load with skip >= ppw yields cnt = 0. The word is never emitted but can still be replayed via rewind (which then also yields nothing). in_rdy stays 1.
- rewind and flush are combinationally gated into in_rdy. An in_vld presented in those cycles is not consumed and must be held.
- All outputs are functions of registered state plus out_rdy/flush/rewind. There is no combinational path from in_data to out_pix.

## Test plan
- Reset/idle: assert rst mid-stream; after release, out_vld=0, out_pix=0, in_rdy=1. A load of 0x76543210 at 4 bpp gives out_vld on the next cycle, with pixels 0,1,2,…,7 over 8 cycles.
- Depth sweep: load 0xA5A5_F00F at each bpp 0..4 with out_rdy=1. Require respectively 32×1-bit, 16×2-bit, 8×4-bit, 4×8-bit (0x0F,0xF0,0xA5,0xA5) and 2×16-bit (0xF00F,0xA5A5) pixels, zero-extended.
- Skip: 0x76543210, 4 bpp, skip=3 gives 3,4,5,6,7 (5 pixels). skip=8 gives no out_vld and in_rdy stays 1.
- Back-to-back and backpressure: two words with in_vld held and out_rdy toggling 1010. Require no lost or duplicated pixels, the second load on the final-pixel handshake cycle, and no gap when out_rdy=1.
- Rewind: after emitting 2 pixels of a 4-bpp word, pulse rewind. Require replay from the post-skip first pixel. Rewind after exhaustion replays the full word. Rewind after flush is a no-op.
- Priority: flush, rewind and in_vld asserted together: cnt=0, sh_vld=0, word not accepted. The next cycle the same word is accepted.
